fighter_sprite_addr: RTL and testbench

FIGHTER_SPRITE_ADDR -- requirements
Module: fighter_sprite_addr

---
 rtl/fighter_pkg.sv | 20 ++
 rtl/fighter_pose_fsm.sv | 70 +++++++
 rtl/fighter_sprite_addr.sv | 95 +++++++++
 tb/tb_fighter_sprite_addr.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// Shared types and default geometry for the fighter sprite address path.
// The address layout is {pose, row, col}.
package fighter_pkg;
    localparam int SPRITE_W_DEF     = 64;
    localparam int SPRITE_H_DEF     = 64;
    localparam int SCREEN_W_DEF     = 640;
    localparam int SCREEN_H_DEF     = 480;
    localparam int PUNCH_FRAMES_DEF = 12;
    localparam int ROM_AW           = 14;

    typedef enum logic [1:0] {
        STAND  = 2'd0,
        CROUCH = 2'd1,
        PUNCH  = 2'd2
    } pose_t;

    function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction
endpackage

// File: rtl/fighter_pose_fsm.sv
// Pose state machine with punch duration counter.
// State advances only on frame_start, so a pose never changes mid-frame.
module fighter_pose_fsm
    import fighter_pkg::*;
#(
    parameter int PUNCH_FRAMES = PUNCH_FRAMES_DEF
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       frame_start_i,
    input  logic       crouch_i,
    input  logic       punch_i,
    output logic [1:0] pose_o
);
    localparam int CW = (PUNCH_FRAMES > 1) ? $clog2(PUNCH_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(PUNCH_FRAMES - 1);

    // Kept as raw bits so an illegal encoding is representable and recoverable.
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (frame_start_i) begin
            case (state_q)
                STAND: begin
                    if (punch_i) begin
                        state_d = PUNCH;
                        cnt_d   = CNT_LOAD;
                    end else if (crouch_i) begin
                        state_d = CROUCH;
                    end
                end
                CROUCH: begin
                    if (punch_i) begin
                        state_d = PUNCH;
                        cnt_d   = CNT_LOAD;
                    end else if (!crouch_i) begin
                        state_d = STAND;
                    end
                end
                PUNCH: begin
                    // punch_i is ignored here: a punch cannot be extended.
                    if (cnt_q == '0) begin
                        state_d = crouch_i ? CROUCH : STAND;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = STAND;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STAND;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pose_o = state_q;
endmodule

// File: rtl/fighter_sprite_addr.sv
// Sprite hit test and ROM address generation for one fighter.
// Position/facing latch at frame_start; hit and address are registered together.
module fighter_sprite_addr
    import fighter_pkg::*;
#(
    parameter int SPRITE_W     = SPRITE_W_DEF,
    parameter int SPRITE_H     = SPRITE_H_DEF,
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int PUNCH_FRAMES = PUNCH_FRAMES_DEF
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_start,
    input  logic [9:0]        req_x,
    input  logic [9:0]        req_y,
    input  logic              crouch,
    input  logic              punch,
    input  logic              facing_left,
    output logic [ROM_AW-1:0] rom_address,
    output logic              sprite_hit,
    output logic [1:0]        pose
);
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam logic [9:0] X_MAX = 10'(SCREEN_W - SPRITE_W);
    localparam logic [9:0] Y_MAX = 10'(SCREEN_H - SPRITE_H);

    logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic              facing_q, facing_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic              hit_q, hit_d;
    logic [1:0]        pose_cur;

    fighter_pose_fsm #(.PUNCH_FRAMES(PUNCH_FRAMES)) u_pose (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .frame_start_i(frame_start),
        .crouch_i     (crouch),
        .punch_i      (punch),
        .pose_o       (pose_cur)
    );

    always_comb begin
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        facing_d = facing_q;
        if (frame_start) begin
            pos_x_d  = clamp10(req_x, X_MAX);
            pos_y_d  = clamp10(req_y, Y_MAX);
            facing_d = facing_left;
        end
    end

    // 11-bit differences: bit 10 set means the pixel is left of / above the sprite.
    logic [10:0]   dx, dy;
    logic          in_x, in_y;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    always_comb begin
        dx    = {1'b0, DrawX} - {1'b0, pos_x_q};
        dy    = {1'b0, DrawY} - {1'b0, pos_y_q};
        in_x  = !dx[10] && (dx[9:0] < 10'(SPRITE_W));
        in_y  = !dy[10] && (dy[9:0] < 10'(SPRITE_H));
        col   = facing_q ? (CW'(SPRITE_W - 1) - dx[CW-1:0]) : dx[CW-1:0];
        row   = dy[RW-1:0];
        hit_d = in_x && in_y && blank;
        // Pose here is the registered state, so a frame_start pixel sees the old pose.
        addr_d = hit_d ? ROM_AW'({pose_cur, row, col}) : '0;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            facing_q <= 1'b0;
            addr_q   <= '0;
            hit_q    <= 1'b0;
        end else begin
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            facing_q <= facing_d;
            addr_q   <= addr_d;
            hit_q    <= hit_d;
        end
    end

    assign rom_address = addr_q;
    assign sprite_hit  = hit_q;
    assign pose        = pose_cur;
endmodule

// File: tb/tb_fighter_sprite_addr.sv
// Directed bench: stimulus pushes expected {hit, addr, pose} per cycle,
// a monitor pops and compares one cycle after each drive.
module tb_fighter_sprite_addr;
    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY, req_x, req_y;
    logic        blank, frame_start, crouch, punch, facing_left;
    logic [13:0] rom_address;
    logic        sprite_hit;
    logic [1:0]  pose;

    fighter_sprite_addr dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .frame_start(frame_start),
        .req_x      (req_x),
        .req_y      (req_y),
        .crouch     (crouch),
        .punch      (punch),
        .facing_left(facing_left),
        .rom_address(rom_address),
        .sprite_hit (sprite_hit),
        .pose       (pose)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int          cyc;
        logic        hit;
        logic [13:0] addr;
        logic [1:0]  pose;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs; ctl inputs change only when fs=1.
    task automatic drive(input logic fs, input logic [9:0] rx, input logic [9:0] ry,
                         input logic cr, input logic pu, input logic fl,
                         input logic [9:0] x, input logic [9:0] y, input logic b,
                         input logic eh, input logic [13:0] ea, input logic [1:0] ep,
                         input string nm);
        exp_t e;
        @(negedge vga_clk);
        frame_start = fs;
        if (fs) begin
            req_x = rx; req_y = ry; crouch = cr; punch = pu; facing_left = fl;
        end
        DrawX = x; DrawY = y; blank = b;
        e.cyc = cyc + 1; e.hit = eh; e.addr = ea; e.pose = ep; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic b,
                       input logic eh, input logic [13:0] ea, input logic [1:0] ep,
                       input string nm);
        drive(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, x, y, b, eh, ea, ep, nm);
    endtask

    task automatic frame(input logic [9:0] rx, input logic [9:0] ry, input logic cr,
                         input logic pu, input logic fl, input logic [1:0] ep,
                         input string nm);
        drive(1'b1, rx, ry, cr, pu, fl, 10'd0, 10'd0, 1'b0, 1'b0, 14'd0, ep, nm);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge vga_clk);
            #1;
            cyc++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc < cyc) begin
                    chk({e.nm, "_cycle"}, e.cyc, cyc);
                end else begin
                    chk({e.nm, "_hit"},  sprite_hit,  e.hit);
                    chk({e.nm, "_addr"}, rom_address, e.addr);
                    chk({e.nm, "_pose"}, pose,        e.pose);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        logic [1:0] ep;
        reset_n = 1'b0; frame_start = 0; blank = 0; DrawX = 0; DrawY = 0;
        req_x = 0; req_y = 0; crouch = 0; punch = 0; facing_left = 0;
        #2;
        chk("rst_hit", sprite_hit, 0);
        chk("rst_addr", rom_address, 0);
        chk("rst_pose", pose, 0);
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;

        // Basic placement and hit at the sprite origin
        frame(10'd100, 10'd200, 0, 0, 0, 2'd0, "f_place");
        pix(10'd100, 10'd200, 1, 1, 14'h0000, 2'd0, "origin");
        pix(10'd99,  10'd200, 1, 0, 14'h0000, 2'd0, "left_miss");

        // Mirrored sprite
        frame(10'd100, 10'd200, 0, 0, 1, 2'd0, "f_mirror");
        pix(10'd100, 10'd263, 1, 1, 14'h0FFF, 2'd0, "mirror_corner");
        pix(10'd164, 10'd263, 1, 0, 14'h0000, 2'd0, "mirror_right_miss");
        pix(10'd163, 10'd200, 1, 1, 14'h0000, 2'd0, "mirror_col0");

        // Clamp to the screen corner
        frame(10'd700, 10'd470, 0, 0, 0, 2'd0, "f_clamp");
        pix(10'd639, 10'd479, 1, 1, 14'h0FFF, 2'd0, "clamp_corner");
        pix(10'd575, 10'd416, 1, 0, 14'h0000, 2'd0, "clamp_left_miss");
        pix(10'd576, 10'd416, 1, 1, 14'h0000, 2'd0, "clamp_origin");

        // frame_start on a visible pixel: old position applies to that pixel
        drive(1'b1, 10'd100, 10'd200, 0, 0, 0, 10'd600, 10'd450, 1, 1, 14'h0898, 2'd0, "fs_overlap");
        pix(10'd600, 10'd450, 1, 0, 14'h0000, 2'd0, "fs_after");

        // Crouch pose, blank gating
        frame(10'd100, 10'd200, 1, 0, 0, 2'd1, "f_crouch");
        pix(10'd110, 10'd205, 0, 0, 14'h0000, 2'd1, "crouch_blank0");
        pix(10'd110, 10'd205, 1, 1, 14'h114A, 2'd1, "crouch_blank1");
        frame(10'd100, 10'd200, 0, 0, 0, 2'd0, "f_stand");

        // Punch for 12 frames, re-pulse ignored, crouch held afterwards
        for (int k = 1; k <= 14; k++) begin
            ep = (k <= 12) ? 2'd2 : 2'd1;
            frame(10'd100, 10'd200, 1, (k == 1 || k == 5 || k == 6), 0, ep, "f_punch");
            pix(10'd100, 10'd200, 1, 1, {ep, 12'h000}, ep, "punch_px");
        end

        // Reset in the middle of a punch
        frame(10'd100, 10'd200, 0, 0, 0, 2'd0, "f_stand2");
        for (int k = 1; k <= 5; k++)
            frame(10'd100, 10'd200, 0, (k == 1), 0, 2'd2, "f_punch2");
        pix(10'd100, 10'd200, 1, 1, 14'h2000, 2'd2, "punch2_px");
        @(negedge vga_clk);
        reset_n = 1'b0;
        #1;
        chk("async_hit", sprite_hit, 0);
        chk("async_addr", rom_address, 0);
        chk("async_pose", pose, 0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        pix(10'd0,  10'd0,  1, 1, 14'h0000, 2'd0, "post_rst_origin");
        pix(10'd63, 10'd63, 1, 1, 14'h0FFF, 2'd0, "post_rst_corner");
        pix(10'd64, 10'd0,  1, 0, 14'h0000, 2'd0, "post_rst_miss");
        frame(10'd100, 10'd200, 1, 0, 0, 2'd1, "f_post_rst");
        pix(10'd100, 10'd200, 1, 1, 14'h1000, 2'd1, "post_rst_crouch");

        repeat (3) @(negedge vga_clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
